// File: rtl/enoc_output_arbiter_pkg.sv
// Shared ENoC arbiter types: packet format, arbiter index type and the
// round-robin increment helper used by the output arbiter and other allocators.
package enoc_output_arbiter_pkg;

    localparam int ARB_N = 4;

    typedef struct packed {
        logic [3:0] dest;
        logic [3:0] data;
    } packet_t;

    typedef logic [$clog2(ARB_N)-1:0] arb_idx_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/enoc_output_arbiter_if.sv
// Bundle between the input FIFO heads, the arbiter and the downstream link.
// Handshake: o_en[k] pops FIFO k on the same edge the arbiter captures
// i_data[k]; o_data is consumed on an edge where o_data_val and i_en are both high.
interface enoc_output_arbiter_if
    import enoc_output_arbiter_pkg::*;
#(
    parameter int N = ARB_N
);
    packet_t [N-1:0] i_data;
    logic    [N-1:0] i_data_val;
    logic    [N-1:0] o_en;
    packet_t         o_data;
    logic            o_data_val;
    logic            i_en;

    modport slave (
        input  i_data, i_data_val, i_en,
        output o_en, o_data, o_data_val
    );

    modport master (
        output i_data, i_data_val, i_en,
        input  o_en, o_data, o_data_val
    );
endinterface

// File: rtl/enoc_rr_pick.sv
// Combinational round-robin picker: first requester at or after i_ptr (mod N).
// Returns a one-hot grant, the binary index of the winner and an any-request flag.
module enoc_rr_pick #(
    parameter int N = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // ptr + offset never reaches 2N, so one conditional subtract replaces a modulo
    function automatic int wrap(input int s);
        return (s >= N) ? s - N : s;
    endfunction

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!o_any && i_req[wrap(int'(i_ptr) + i)]) begin
                o_any                          = 1'b1;
                o_idx                          = IDX_W'(wrap(int'(i_ptr) + i));
                o_grant[wrap(int'(i_ptr) + i)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/enoc_output_arbiter.sv
// Round-robin N:1 output arbiter with a single registered output stage.
// Optional per-input saturating grant counters under ENOC_ARB_COUNT_EN.
module enoc_output_arbiter
    import enoc_output_arbiter_pkg::*;
#(
    parameter int N     = ARB_N,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ce,
    enoc_output_arbiter_if.slave    bus
`ifdef ENOC_ARB_COUNT_EN
    ,
    output logic [N-1:0][CNT_W-1:0] o_grant_cnt
`endif
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] r_rr_ptr;
    packet_t          r_data;
    logic             r_data_val;

    logic [N-1:0]     w_grant;
    logic [IDX_W-1:0] w_idx;
    logic             w_any;
    logic             w_load;
    logic [N-1:0]     w_en;

    enoc_rr_pick #(.N(N)) u_pick (
        .i_req   (bus.i_data_val),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // The stage may refill whenever it is empty or being drained this edge
    assign w_load = ce & ~reset & (~r_data_val | bus.i_en);
    assign w_en   = (w_load && w_any) ? w_grant : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data     <= '0;
            r_data_val <= 1'b0;
            r_rr_ptr   <= '0;
        end else if (w_load) begin
            if (w_any) begin
                r_data     <= bus.i_data[w_idx];
                r_data_val <= 1'b1;
                r_rr_ptr   <= IDX_W'(rr_next(int'(w_idx), N));
            end else begin
                r_data_val <= 1'b0;
            end
        end
    end

    assign bus.o_en       = w_en;
    assign bus.o_data     = r_data;
    assign bus.o_data_val = r_data_val;

`ifdef ENOC_ARB_COUNT_EN
    logic [N-1:0][CNT_W-1:0] r_grant_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant_cnt <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (w_en[k] && (r_grant_cnt[k] != {CNT_W{1'b1}})) begin
                    r_grant_cnt[k] <= r_grant_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign o_grant_cnt = r_grant_cnt;
`endif

endmodule

// File: doc/enoc_output_arbiter.md
# enoc_output_arbiter

Round-robin N:1 output arbiter for the ENoC router. It sits directly downstream of the per-input-port packet FIFOs (LIB FIFO instances of `packet_t`). Each cycle it picks one non-empty FIFO head, pops it through that FIFO's read-enable and registers the packet into a single output stage. The output stage is held until the downstream link (next FIFO or sink) accepts it.

## Interface
Parameters:
- `N`, default 4: number of input FIFOs; N ≥ 2.
- `CNT_W`, default 16: grant counter width; used only with `ENOC_ARB_COUNT_EN`.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ce`  in  1  clock enable; state updates only when high.
- `i_data`  in  N×`packet_t`  head packet of each input FIFO.
- `i_data_val`  in  N  head-valid (FIFO non-empty) per input.
- `o_en`  out  N  one-hot pop to input FIFOs; combinational.
- `o_data`  out  `packet_t`  registered output packet.
- `o_data_val`  out  1  output register holds a packet.
- `i_en`  in  1  downstream accepted `o_data` this cycle.
- `o_grant_cnt`  out  N×`CNT_W`  per-input grant counters; present only with `ENOC_ARB_COUNT_EN`.

## Operation
- State:
  - Output register: `o_data`, `o_data_val`.
  - Round-robin pointer `rr_ptr`: the highest-priority index, 0..N-1.
- Load condition: `load = ce & ~reset & (~o_data_val | i_en)`.
- Winner: the first index k, scanning `rr_ptr, rr_ptr+1, …` modulo N, with `i_data_val[k]=1`.
- `o_en[k] = load & any(i_data_val) & (k == winner)`. At most one bit is high, and it is never high for an input whose valid is low.
- On a clock edge with `load`:
  - If any input is valid: `o_data <= i_data[winner]`, `o_data_val <= 1`, `rr_ptr <= (winner+1) mod N`. Wrap from N-1 to 0.
  - If no input is valid: `o_data_val <= 0`, `o_data` unchanged, `rr_ptr` unchanged.
- On a clock edge without `load`: all state holds (stall).
- `i_en` while `o_data_val=0` is ignored.
- Fairness: with all N inputs continuously valid and no stalls, grants go in strict rotation, and each input is served exactly once per N accepted packets.
- `ce=0`: no state change, `o_en=0`, `i_en` ignored. The packet in the output register is neither lost nor duplicated.
- Reset, including mid-operation:
  - `o_data_val=0`, `o_data='0`, `rr_ptr=0`, `o_en=0`, counters 0.
  - A packet in the output register is discarded; no input is popped during the reset cycle.

## Timing
- Latency: a head valid at edge t with the output register free leaves on `o_data` after edge t; `o_data_val=1` in cycle t+1.
- Throughput: 1 packet/cycle when `i_en=1` every cycle. Accept and reload happen on the same edge (back-to-back).
- Pop and capture are atomic. `o_en[k]` in cycle t means the FIFO advances at edge t and the register captures `i_data[k]` at the same edge.
- `o_en` depends combinationally on `i_data_val`, `i_en`, `o_data_val`, `ce`, `reset`. There is no path from `i_data` to `o_en`.
- `o_data`/`o_data_val` are registered only, with no combinational path from the inputs.

## Configuration
- Macro `ENOC_ARB_COUNT_EN`.
- Defined:
  - `o_grant_cnt` exists.
  - Counter k increments on every edge where `o_en[k]=1`.
  - Counters saturate at 2^`CNT_W`−1 and clear on `reset`.
- Undefined: the port and counters are absent; arbitration behaviour is identical.

## Structure
- Shared package (alongside `packet_t` in ENoC config):
  - `packet_t` (existing).
  - `arb_idx_t` = `logic [$clog2(N)-1:0]`.
  - Helper function `rr_next(idx, N)` for modulo-N increment.
- One sub-module, `enoc_rr_pick`: purely combinational. Inputs are the request vector and `rr_ptr`; outputs are a one-hot grant, the binary winner index and `any`. It is reusable by other allocators.
- The top level holds the output register, the pointer and the optional counters.

## Test plan
- Reset, then a single request: `i_data_val=4'b0100`, `i_data[2].data=4'hD`, `i_en=1` → `o_en=4'b0100` for one cycle; next cycle `o_data.data=4'hD`, `o_data_val=1`, `rr_ptr=3`.
- All four valid continuously with `i_en=1`, `rr_ptr=0` → grants 0,1,2,3,0,1 on consecutive cycles; `o_data_val` stays 1.
- Stall: `o_data_val=1` with `4'hA` held and `i_en=0` for 3 cycles while all inputs are valid → `o_en=0`, `o_data` stays `4'hA`; on `i_en=1`, the next winner loads on that edge.
- Wrap/skip: `rr_ptr=3`, `i_data_val=4'b0010` → input 1 is granted and `rr_ptr` becomes 2. Then `i_data_val=0` with `i_en=1` → `o_data_val` drops to 0.
- Reset mid-stream with `o_data_val=1`, all inputs valid → `o_en=0` during reset; afterwards `o_data_val=0`, `rr_ptr=0`, and the first grant goes to input 0. With `ce=0`, nothing changes.
- `ENOC_ARB_COUNT_EN` with `CNT_W=2`: grant input 0 five times → `o_grant_cnt[0]=3` (saturated) and other counters 0.
